// File: rtl/axis_out_packer.sv
// Byte-stream packer: merges variable-width upstream beats into full-width
// downstream beats, flushing a partial beat at end of packet.
module axis_out_packer #(
  parameter int DATA_WIDTH = 128,
  parameter int W_BPT      = 5,
  parameter int CNT_BITS   = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  input  logic [W_BPT-1:0]        s_bytes_per_transfer,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [DATA_WIDTH/8-1:0] m_keep,
  output logic                    m_last,
  output logic [CNT_BITS-1:0]     pkt_bytes
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AB = 2 * NB;
  localparam int FW = $clog2(AB) + 1;

  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic                    last_pending_q, last_pending_d;
  logic [CNT_BITS-1:0]     run_cnt_q, run_cnt_d;
  logic [CNT_BITS-1:0]     pkt_bytes_q, pkt_bytes_d;

  logic [31:0]             bpt_raw;
  logic [FW-1:0]           bpt;
  logic [FW-1:0]           base;
  logic                    full;
  logic                    out_hs;
  logic                    in_acc;
  logic                    last_hs;
  logic [AB-1:0]           wr_mask;
  logic [2*DATA_WIDTH-1:0] wr_bits;
  logic [2*DATA_WIDTH-1:0] wr_data;
  logic [2*DATA_WIDTH-1:0] acc_base;
  logic [DATA_WIDTH-1:0]   keep_bits;

  assign bpt_raw = 32'(s_bytes_per_transfer);
  assign bpt     = (bpt_raw == 32'd0 || bpt_raw > 32'(NB)) ? FW'(NB) : FW'(bpt_raw);

  assign full    = (fill_q >= FW'(NB));
  assign m_valid = full || (last_pending_q && (fill_q != '0));
  assign m_last  = m_valid && last_pending_q && (fill_q <= FW'(NB));
  // Gating with the reset input keeps s_ready low while reset is held.
  assign s_ready = aresetn && !last_pending_q && (!full || m_ready);

  assign out_hs  = m_valid && m_ready;
  assign in_acc  = s_valid && s_ready;
  assign last_hs = out_hs && m_last;

  // Drain happens first, so new bytes land just above what remains after the shift.
  assign acc_base = out_hs ? {{DATA_WIDTH{1'b0}}, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} : acc_q;
  assign base     = out_hs ? (full ? fill_q - FW'(NB) : '0) : fill_q;
  assign wr_mask  = (~({AB{1'b1}} << bpt)) << base;
  assign wr_data  = {{DATA_WIDTH{1'b0}}, s_data} << {base, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < AB; gi++) begin : g_wr_bits
      assign wr_bits[gi*8 +: 8] = {8{wr_mask[gi]}};
    end
    for (gi = 0; gi < NB; gi++) begin : g_keep_bits
      assign keep_bits[gi*8 +: 8] = {8{m_keep[gi]}};
    end
  endgenerate

  assign m_keep    = full ? {NB{1'b1}} : ~({NB{1'b1}} << fill_q);
  // Lanes past the fill level hold stale bytes; mask them to zero.
  assign m_data    = acc_q[DATA_WIDTH-1:0] & keep_bits;
  assign pkt_bytes = pkt_bytes_q;

  always_comb begin
    acc_d          = in_acc ? ((acc_base & ~wr_bits) | (wr_data & wr_bits)) : acc_base;
    fill_d         = base + (in_acc ? bpt : '0);
    last_pending_d = last_pending_q;
    run_cnt_d      = run_cnt_q;
    pkt_bytes_d    = pkt_bytes_q;
    if (in_acc) begin
      run_cnt_d = run_cnt_q + CNT_BITS'(bpt);
      if (s_last) begin
        last_pending_d = 1'b1;
      end
    end
    if (last_hs) begin
      fill_d         = '0;
      last_pending_d = 1'b0;
      pkt_bytes_d    = run_cnt_q;
      run_cnt_d      = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q          <= '0;
      fill_q         <= '0;
      last_pending_q <= 1'b0;
      run_cnt_q      <= '0;
      pkt_bytes_q    <= '0;
    end else begin
      acc_q          <= acc_d;
      fill_q         <= fill_d;
      last_pending_q <= last_pending_d;
      run_cnt_q      <= run_cnt_d;
      pkt_bytes_q    <= pkt_bytes_d;
    end
  end

endmodule

// File: tb/tb_axis_out_packer.sv
// Directed bench for axis_out_packer: packet table plus hand-written
// backpressure and mid-packet reset sequences.
module tb_axis_out_packer;

  localparam int NB = 16;

  logic         aclk;
  logic         aresetn;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         s_last;
  logic [4:0]   s_bytes_per_transfer;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic [15:0]  m_keep;
  logic         m_last;
  logic [31:0]  pkt_bytes;

  int tests = 0;
  int fails = 0;

  axis_out_packer #(.DATA_WIDTH(128), .W_BPT(5), .CNT_BITS(32)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .s_data               (s_data),
    .s_last               (s_last),
    .s_bytes_per_transfer (s_bytes_per_transfer),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_data               (m_data),
    .m_keep               (m_keep),
    .m_last               (m_last),
    .pkt_bytes            (pkt_bytes)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int          nbeats;
    int          bpt_field;
    int          rdy_mode;
    int          exp_total;
    int          exp_beats;
    logic [15:0] exp_last_keep;
  } pkt_vec_t;

  pkt_vec_t vecs[7];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Input beat: bytes start.. in the low n lanes, filler above.
  function automatic logic [127:0] mk_beat(input int start, input int n);
    logic [127:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = (i < n) ? 8'(start + i) : 8'hEE;
    return r;
  endfunction

  // Expected output beat: bytes start.. in the low n lanes, zero above.
  function automatic logic [127:0] exp_data(input int start, input int n);
    logic [127:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = (i < n) ? 8'(start + i) : 8'h00;
    return r;
  endfunction

  task automatic run_packet(input int nbeats, input int bfield, input int rdy_mode,
                            input int base, input int exp_total, input int exp_beats,
                            input logic [15:0] exp_last_keep);
    int eff, sent, outs, cyc, first_out, last_out;
    bit done, stream_ok;
    eff = (bfield == 0 || bfield > NB) ? NB : bfield;
    sent = 0; outs = 0; cyc = 0; done = 0; first_out = -1; last_out = -1; stream_ok = 1;
    while (!done && cyc < 400) begin
      @(posedge aclk); #1;
      s_valid = (sent < nbeats);
      s_data  = mk_beat(base + sent * eff, eff);
      s_bytes_per_transfer = 5'(bfield);
      s_last  = (sent == nbeats - 1);
      m_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 1);
      @(negedge aclk);
      if (s_valid && !s_ready && rdy_mode == 0 && eff == NB) stream_ok = 0;
      if (m_valid && m_ready) begin
        check("keep", m_keep, (outs == exp_beats - 1) ? exp_last_keep : 16'hFFFF);
        check("data", m_data, exp_data(base + outs * NB, exp_total - outs * NB));
        check("last", m_last, outs == exp_beats - 1);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (m_last) done = 1;
        outs++;
      end
      if (s_valid && s_ready) sent++;
      cyc++;
    end
    check("timeout", done, 1'b1);
    check("beat_count", outs, exp_beats);
    @(posedge aclk); #1;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    check("pkt_bytes", pkt_bytes, exp_total);
    if (rdy_mode == 0 && eff == NB) begin
      check("stream_ready", stream_ok, 1'b1);
      check("consecutive", last_out - first_out, exp_beats - 1);
    end
    $display("[TB] packet beats=%0d bpt=%0d rdy=%0d -> out=%0d pkt_bytes=%0d",
             nbeats, bfield, rdy_mode, outs, pkt_bytes);
  endtask

  initial begin
    vecs[0] = '{nbeats: 4,  bpt_field: 4,  rdy_mode: 0, exp_total: 16, exp_beats: 1, exp_last_keep: 16'hFFFF};
    vecs[1] = '{nbeats: 3,  bpt_field: 6,  rdy_mode: 0, exp_total: 18, exp_beats: 2, exp_last_keep: 16'h0003};
    vecs[2] = '{nbeats: 10, bpt_field: 16, rdy_mode: 0, exp_total: 160, exp_beats: 10, exp_last_keep: 16'hFFFF};
    vecs[3] = '{nbeats: 2,  bpt_field: 0,  rdy_mode: 0, exp_total: 32, exp_beats: 2, exp_last_keep: 16'hFFFF};
    vecs[4] = '{nbeats: 5,  bpt_field: 17, rdy_mode: 0, exp_total: 80, exp_beats: 5, exp_last_keep: 16'hFFFF};
    vecs[5] = '{nbeats: 3,  bpt_field: 1,  rdy_mode: 0, exp_total: 3,  exp_beats: 1, exp_last_keep: 16'h0007};
    vecs[6] = '{nbeats: 7,  bpt_field: 5,  rdy_mode: 1, exp_total: 35, exp_beats: 3, exp_last_keep: 16'h0007};

    aresetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_bytes_per_transfer = '0; m_ready = 1'b0;

    // Reset state while held
    #12;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_keep", m_keep, 16'h0);
    check("rst_m_data", m_data, 128'h0);
    check("rst_pkt_bytes", pkt_bytes, 32'h0);
    check("rst_s_ready", s_ready, 1'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_s_ready", s_ready, 1'b1);
    check("post_rst_m_valid", m_valid, 1'b0);

    for (int v = 0; v < 7; v++) begin
      run_packet(vecs[v].nbeats, vecs[v].bpt_field, vecs[v].rdy_mode, 0,
                 vecs[v].exp_total, vecs[v].exp_beats, vecs[v].exp_last_keep);
    end

    // Backpressure with fill=20: output must hold still, then drain to fill=4
    @(posedge aclk); #1;
    s_valid = 1'b1; s_data = mk_beat(0, 4); s_bytes_per_transfer = 5'd4; s_last = 1'b0; m_ready = 1'b0;
    @(negedge aclk);
    check("bp_acc0", s_ready, 1'b1);
    @(posedge aclk); #1;
    s_data = mk_beat(4, 16); s_bytes_per_transfer = 5'd16;
    @(negedge aclk);
    check("bp_acc1", s_ready, 1'b1);
    @(posedge aclk); #1;
    s_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("bp_m_valid", m_valid, 1'b1);
      check("bp_s_ready", s_ready, 1'b0);
      check("bp_hold_data", m_data, exp_data(0, 16));
      @(posedge aclk); #1;
    end
    m_ready = 1'b1;
    @(negedge aclk);
    check("bp_release_data", m_data, exp_data(0, 16));
    check("bp_release_s_ready", s_ready, 1'b1);
    @(posedge aclk); #1;
    m_ready = 1'b0;
    @(negedge aclk);
    check("bp_left_valid", m_valid, 1'b0);
    check("bp_left_keep", m_keep, 16'h000F);
    @(posedge aclk); #1;
    s_valid = 1'b1; s_data = mk_beat(20, 12); s_bytes_per_transfer = 5'd12; s_last = 1'b1; m_ready = 1'b1;
    @(negedge aclk);
    check("bp_tail_acc", s_ready, 1'b1);
    @(posedge aclk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge aclk);
    check("bp_tail_valid", m_valid, 1'b1);
    check("bp_tail_last", m_last, 1'b1);
    check("bp_tail_keep", m_keep, 16'hFFFF);
    check("bp_tail_data", m_data, exp_data(16, 16));
    @(posedge aclk); #1;
    m_ready = 1'b0;
    check("bp_pkt_bytes", pkt_bytes, 32'd32);
    $display("[TB] backpressure sequence pkt_bytes=%0d", pkt_bytes);

    // Reset after 2 of 4 beats, then a clean 16-byte packet
    for (int k = 0; k < 2; k++) begin
      @(posedge aclk); #1;
      s_valid = 1'b1; s_data = mk_beat(k * 4, 4); s_bytes_per_transfer = 5'd4; s_last = 1'b0; m_ready = 1'b1;
      @(negedge aclk);
      check("mid_acc", s_ready, 1'b1);
    end
    @(posedge aclk); #1;
    s_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_keep", m_keep, 16'h0);
    check("mid_rst_m_data", m_data, 128'h0);
    check("mid_rst_m_last", m_last, 1'b0);
    check("mid_rst_pkt_bytes", pkt_bytes, 32'h0);
    check("mid_rst_s_ready", s_ready, 1'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    run_packet(1, 16, 0, 8'h80, 16, 1, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_out_packer.md
AXIS_OUT_PACKER -- requirements
Module: axis_out_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: width of s_data and m_data in bits; NB = DATA_WIDTH/8 bytes.
REQ-002 SHALL have parameter W_BPT, default 5: width of s_bytes_per_transfer; W_BPT = $clog2(NB)+1.
REQ-003 SHALL have parameter CNT_BITS, default 32: width of pkt_bytes.
REQ-004 aclk  in  1  single clock; all state updates on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous and active-low.
REQ-006 s_valid  in  1  upstream beat valid.
REQ-007 s_ready  out  1  upstream beat accepted when s_valid && s_ready.
REQ-008 s_data  in  DATA_WIDTH  upstream beat; valid bytes occupy the low-order bytes.
REQ-009 s_last  in  1  final beat of packet.
REQ-010 s_bytes_per_transfer  in  W_BPT  number of valid low-order bytes in the s_data beat.
REQ-011 m_valid  out  1  downstream beat valid.
REQ-012 m_ready  in  1  downstream ready.
REQ-013 m_data  out  DATA_WIDTH  packed bytes; byte 0 is the oldest.
REQ-014 m_keep  out  NB  byte enables.
REQ-015 m_last  out  1  final beat of packet.
REQ-016 pkt_bytes  out  CNT_BITS  total bytes of the last completed packet.

Function
REQ-017 SHALL hold a 2*NB-byte accumulator acc and a fill count (0..2*NB-1).
REQ-018 SHALL hold a last_pending flag and a running byte counter run_cnt.
REQ-019 SHALL compute the effective byte count as bpt = (s_bytes_per_transfer==0 || s_bytes_per_transfer>NB) ? NB : s_bytes_per_transfer.
REQ-020 SHALL drive s_ready = !last_pending && (fill < NB || m_ready); s_ready is combinational in m_ready.
REQ-021 SHALL assert m_valid when fill >= NB, or when last_pending && fill > 0.
REQ-022 SHALL drive m_data = acc bytes [0..NB-1], and SHALL hold it stable while m_valid && !m_ready.
REQ-023 SHALL drive m_keep as all ones when fill >= NB, otherwise as the low fill bits set.
REQ-024 SHALL assert m_last = last_pending && fill <= NB.
REQ-025 On output handshake only: SHALL shift acc down by NB bytes and set fill = max(fill-NB, 0).
REQ-026 On input accept only: SHALL write s_data low bpt bytes to acc[fill .. fill+bpt-1] and set fill += bpt.
REQ-027 On simultaneous input accept and output handshake: SHALL shift acc first, write the input at offset fill-NB, and set fill = fill-NB+bpt; no byte lost or duplicated.
REQ-028 SHALL sustain one accepted beat per cycle at bpt=NB while m_ready=1.
REQ-029 On accept with s_last=1: SHALL set last_pending, then block input until the m_last handshake.
REQ-030 On the m_last handshake: SHALL clear last_pending, set fill=0, load pkt_bytes = run_cnt, and clear run_cnt.
REQ-031 run_cnt SHALL add bpt on every accept and SHALL wrap modulo 2^CNT_BITS.
REQ-032 SHALL make bytes beyond fill in acc don't-care, but m_data SHALL read zero in those lanes for a partial beat.
REQ-033 SHALL produce packet output latency of one cycle from fill crossing NB to m_valid; there is no combinational path from s_data to m_data.

Reset
REQ-034 aresetn low SHALL immediately force m_valid=0, m_last=0, m_keep=0, m_data=0, fill=0, last_pending=0, run_cnt=0, and pkt_bytes=0.
REQ-035 s_ready SHALL read 0 during reset and 1 in the first cycle after release.
REQ-036 Reset mid-packet SHALL discard all buffered bytes; the next packet SHALL start at byte 0.

Verification
REQ-037 4 beats bpt=4 (bytes 0x00..0x0F), last on 4th, m_ready=1 -> one beat, m_keep=0xFFFF, m_last=1, m_data bytes 0x00..0x0F in order, pkt_bytes=16.
REQ-038 3 beats bpt=6, last on 3rd -> beat A full with m_keep=0xFFFF and m_last=0, then beat B with m_keep=0x0003 and m_last=1; pkt_bytes=18.
REQ-039 10 beats bpt=16 with m_ready=1 -> s_ready stays 1, ten output beats on consecutive cycles, m_last on the 10th.
REQ-040 fill=20 with m_ready=0 -> m_valid=1, s_ready=0, m_data stable for 5 cycles; m_ready=1 then emits bytes 0..15 and leaves fill=4.
REQ-041 bpt=0 on every beat, 2 beats, last on 2nd -> treated as 16, giving 2 full beats and pkt_bytes=32.
REQ-042 aresetn pulsed after 2 of 4 beats -> all outputs zero; a new 16-byte packet emits exactly one beat with no stale bytes.
